// File: rtl/cursor_ctrl_pkg.sv
// Shared definitions for the text-cursor controller: opcodes, FSM states,
// geometry defaults and blink counter width.
package cursor_ctrl_pkg;

   localparam int COLS_DEF      = 80;
   localparam int ROWS_DEF      = 30;
   localparam int BLINK_RST_DEF = 30;
   localparam int CNT_W         = 8;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_SET_ROW   = 3'd1,
      OP_SET_COL   = 3'd2,
      OP_ADVANCE   = 3'd3,
      OP_NEWLINE   = 3'd4,
      OP_BACK      = 3'd5,
      OP_ENABLE    = 3'd6,
      OP_SET_BLINK = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SCROLL_WAIT
   } state_e;

endpackage

// File: rtl/cursor_blink.sv
// Cursor blink timing: vsync synchroniser, frame-tick edge detect and
// half-period counter driving the flash phase.
module cursor_blink
   import cursor_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             vsync_i,
   input  logic             restart_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             phase_o
);

   logic [1:0]       sync_q;
   logic             vs_prev_q;
   logic             tick;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   assign tick = sync_q[1] & ~vs_prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q    <= '0;
         vs_prev_q <= 1'b0;
         cnt_q     <= '0;
         phase_q   <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], vsync_i};
         vs_prev_q <= sync_q[1];
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
      end
   end

   // A restart takes priority over a coincident frame tick.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart_i || (period_i == '0)) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (tick) begin
         if (cnt_q == period_i - CNT_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Text-cursor controller: command handshake FSM, cursor position/enable
// registers and scroll request, with blink timing in cursor_blink.
module cursor_ctrl
   import cursor_ctrl_pkg::*;
#(
   parameter int COLS      = COLS_DEF,
   parameter int ROWS      = ROWS_DEF,
   parameter int BLINK_RST = BLINK_RST_DEF
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       vsync_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [2:0] cmd_op_i,
   input  logic [7:0] cmd_data_i,
   output logic       scroll_req_o,
   input  logic       scroll_ack_i,
   output logic       err_o,
   output logic       cursor_en_o,
   output logic       c_flash_o,
   output logic [7:0] cursor_row_o,
   output logic [7:0] cursor_col_o
);

   localparam logic [7:0] COLS_L  = 8'(COLS);
   localparam logic [7:0] ROWS_L  = 8'(ROWS);
   localparam logic [7:0] COL_MAX = 8'(COLS - 1);
   localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       row_q, row_d;
   logic [7:0]       col_q, col_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             err;
   logic             scroll_need;
   logic             restart;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NOP;
         data_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         en_q     <= 1'b0;
         period_q <= CNT_W'(BLINK_RST);
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         row_q    <= row_d;
         col_q    <= col_d;
         en_q     <= en_d;
         period_q <= period_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      row_d       = row_q;
      col_d       = col_q;
      en_d        = en_q;
      period_d    = period_q;
      err         = 1'b0;
      scroll_need = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               op_d    = op_e'(cmd_op_i);
               data_d  = cmd_data_i;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_SET_ROW: begin
                  if (data_q < ROWS_L) row_d = data_q;
                  else                 err   = 1'b1;
               end
               OP_SET_COL: begin
                  if (data_q < COLS_L) col_d = data_q;
                  else                 err   = 1'b1;
               end
               OP_ADVANCE: begin
                  if (col_q < COL_MAX) begin
                     col_d = col_q + 8'd1;
                  end else begin
                     col_d = '0;
                     if (row_q == ROW_MAX) scroll_need = 1'b1;
                     else                  row_d       = row_q + 8'd1;
                  end
               end
               OP_NEWLINE: begin
                  col_d = '0;
                  if (row_q == ROW_MAX) scroll_need = 1'b1;
                  else                  row_d       = row_q + 8'd1;
               end
               OP_BACK: begin
                  if (col_q != '0) begin
                     col_d = col_q - 8'd1;
                  end else if (row_q != '0) begin
                     col_d = COL_MAX;
                     row_d = row_q - 8'd1;
                  end
               end
               OP_ENABLE:    en_d     = data_q[0];
               OP_SET_BLINK: period_d = CNT_W'(data_q);
               default:      ;
            endcase
            state_d = scroll_need ? ST_SCROLL_WAIT : ST_IDLE;
         end
         ST_SCROLL_WAIT: begin
            if (scroll_ack_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only a real position change or a new blink period restarts the blink.
   assign restart = (state_q == ST_EXEC) &&
                    ((row_d != row_q) || (col_d != col_q) || (op_q == OP_SET_BLINK));

   cursor_blink u_blink (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .vsync_i  (vsync_i),
      .restart_i(restart),
      .period_i (period_q),
      .phase_o  (c_flash_o)
   );

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign scroll_req_o = (state_q == ST_SCROLL_WAIT);
   assign err_o        = err;
   assign cursor_en_o  = en_q;
   assign cursor_row_o = row_q;
   assign cursor_col_o = col_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl: directed scenarios plus random commands
// against a linear-position reference model.
module tb_cursor_ctrl;

   localparam int COLS      = 80;
   localparam int ROWS      = 30;
   localparam int BLINK_RST = 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vsync;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       scroll_req;
   logic       scroll_ack;
   logic       err;
   logic       cursor_en;
   logic       c_flash;
   logic [7:0] cursor_row;
   logic [7:0] cursor_col;

   int checks = 0;
   int errors = 0;

   // Reference model: position as a linear cell index, blink as ticks since restart.
   int m_pos;
   int m_en;
   int m_period;
   int m_ticks;

   always #5 clk = ~clk;

   cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_RST(BLINK_RST)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .vsync_i      (vsync),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_op_i     (cmd_op),
      .cmd_data_i   (cmd_data),
      .scroll_req_o (scroll_req),
      .scroll_ack_i (scroll_ack),
      .err_o        (err),
      .cursor_en_o  (cursor_en),
      .c_flash_o    (c_flash),
      .cursor_row_o (cursor_row),
      .cursor_col_o (cursor_col)
   );

   function automatic int exp_phase();
      if (m_period == 0) return 1;
      return (((m_ticks / m_period) % 2) == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".row"},   32'(cursor_row), 32'(m_pos / COLS));
      chk({tag, ".col"},   32'(cursor_col), 32'(m_pos % COLS));
      chk({tag, ".en"},    32'(cursor_en),  32'(m_en));
      chk({tag, ".flash"}, 32'(c_flash),    32'(exp_phase()));
   endtask

   task automatic model_reset();
      m_pos    = 0;
      m_en     = 0;
      m_period = BLINK_RST;
      m_ticks  = 0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      vsync      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_data   = '0;
      scroll_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_state("reset");
      chk("reset.ready",  32'(cmd_ready),  32'd1);
      chk("reset.scroll", 32'(scroll_req), 32'd0);
      chk("reset.err",    32'(err),        32'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One vsync pulse; the frame tick lands while vsync is still high.
   task automatic frame();
      @(negedge clk);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      if (m_period != 0) m_ticks++;
   endtask

   task automatic ack_scroll(input int delay);
      repeat (delay) @(negedge clk);
      chk("ack.req_held", 32'(scroll_req), 32'd1);
      scroll_ack = 1'b1;
      @(posedge clk); #1;
      chk("ack.req_drop", 32'(scroll_req), 32'd0);
      chk("ack.ready",    32'(cmd_ready),  32'd1);
      @(negedge clk);
      scroll_ack = 1'b0;
   endtask

   // Issue one command; ack_delay < 0 leaves a requested scroll pending.
   task automatic send(input logic [2:0] op, input logic [7:0] data, input int ack_delay);
      int row, col, p, exp_err, scr;
      @(negedge clk);
      chk("cmd.ready_before", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      row = m_pos / COLS;
      col = m_pos % COLS;
      p = m_pos; exp_err = 0; scr = 0;
      case (op)
         3'd1: if (int'(data) >= ROWS) exp_err = 1; else p = int'(data) * COLS + col;
         3'd2: if (int'(data) >= COLS) exp_err = 1; else p = row * COLS + int'(data);
         3'd3: begin
            p = m_pos + 1;
            if (p == ROWS * COLS) begin p = (ROWS - 1) * COLS; scr = 1; end
         end
         3'd4: begin
            p = (row + 1) * COLS;
            if (p == ROWS * COLS) begin p = (ROWS - 1) * COLS; scr = 1; end
         end
         3'd5: if (p > 0) p--;
         default: ;
      endcase
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("exec.ready", 32'(cmd_ready),  32'd0);
      chk("exec.err",   32'(err),        32'(exp_err));
      chk("exec.row",   32'(cursor_row), 32'(row));
      chk("exec.col",   32'(cursor_col), 32'(col));
      if (p != m_pos) m_ticks = 0;
      m_pos = p;
      if (op == 3'd6) m_en = int'(data[0]);
      if (op == 3'd7) begin m_period = int'(data); m_ticks = 0; end
      @(posedge clk); #1;
      chk_state("done");
      chk("done.err",    32'(err),        32'd0);
      chk("done.scroll", 32'(scroll_req), 32'(scr));
      chk("done.ready",  32'(cmd_ready),  32'(scr == 0));
      if (scr != 0 && ack_delay >= 0) ack_scroll(ack_delay);
   endtask

   initial begin
      do_reset();

      // Basic moves with wrap on ADVANCE.
      send(3'd1, 8'd5, 0);
      send(3'd2, 8'd79, 0);
      send(3'd3, 8'd0, 0);
      chk("adv_wrap.row", 32'(cursor_row), 32'd6);
      chk("adv_wrap.col", 32'(cursor_col), 32'd0);

      // Scroll at bottom-right; a NEWLINE waiting meanwhile must stall.
      send(3'd1, 8'd29, 0);
      send(3'd2, 8'd79, 0);
      send(3'd3, 8'd0, -1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 8'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall.req",   32'(scroll_req), 32'd1);
         chk("stall.ready", 32'(cmd_ready),  32'd0);
         chk("stall.row",   32'(cursor_row), 32'd29);
         chk("stall.col",   32'(cursor_col), 32'd0);
      end
      scroll_ack = 1'b1;
      @(posedge clk); #1;
      chk("stall.req_drop", 32'(scroll_req), 32'd0);
      chk("stall.idle",     32'(cmd_ready),  32'd1);
      @(negedge clk);
      scroll_ack = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("nl.exec_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("nl.scroll", 32'(scroll_req), 32'd1);
      chk_state("nl");
      ack_scroll(2);

      // Ack outside SCROLL_WAIT is ignored.
      @(negedge clk);
      scroll_ack = 1'b1;
      repeat (2) @(negedge clk);
      scroll_ack = 1'b0;
      chk("stray_ack.req",   32'(scroll_req), 32'd0);
      chk("stray_ack.ready", 32'(cmd_ready),  32'd1);
      chk_state("stray_ack");

      // Out-of-range operands and BACK at origin.
      send(3'd1, 8'd30, 0);
      send(3'd2, 8'd80, 0);
      send(3'd1, 8'd0, 0);
      send(3'd2, 8'd0, 0);
      send(3'd5, 8'd0, 0);
      send(3'd6, 8'd1, 0);

      // Blink with period 3, then steady with period 0.
      send(3'd7, 8'd3, 0);
      for (int i = 0; i < 12; i++) begin
         frame();
         chk("blink3.flash", 32'(c_flash), 32'(exp_phase()));
      end
      send(3'd7, 8'd0, 0);
      for (int i = 0; i < 4; i++) begin
         frame();
         chk("blink0.flash", 32'(c_flash), 32'd1);
      end

      // Position change coinciding with the toggling tick: restart wins.
      send(3'd7, 8'd3, 0);
      frame();
      frame();
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      m_pos = (m_pos / COLS) * COLS + 4;
      m_ticks = 0;
      chk("coinc.flash", 32'(c_flash), 32'd1);
      chk("coinc.col",   32'(cursor_col), 32'd4);
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         frame();
         chk("coinc_after.flash", 32'(c_flash), 32'(exp_phase()));
      end

      // Random commands against the model.
      for (int i = 0; i < 60; i++) begin
         logic [2:0] op;
         logic [7:0] data;
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       data = 8'($urandom_range(0, 90));
            1:       data = 8'($urandom_range(26, 31));
            default: data = 8'($urandom);
         endcase
         if (op == 3'd7) data = 8'($urandom_range(0, 4));
         send(op, data, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) begin
            frame();
            chk("rand.flash", 32'(c_flash), 32'(exp_phase()));
         end
      end

      // Asynchronous reset while a scroll is pending.
      send(3'd1, 8'd29, 0);
      send(3'd2, 8'd79, 0);
      send(3'd6, 8'd1, 0);
      send(3'd3, 8'd0, -1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.req",   32'(scroll_req), 32'd0);
      chk("arst.ready", 32'(cmd_ready),  32'd1);
      chk("arst.err",   32'(err),        32'd0);
      chk_state("arst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_after.req", 32'(scroll_req), 32'd0);
      chk_state("arst_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
